// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, types and helpers for the clk_div_multi
// programmable tick/clock generator.
//   CW_DEFAULT      default divisor/counter width
//   DEF_DIV_DEFAULT default divisor loaded at reset
//   idx_w()         channel-select width, max(1, clog2(n))
//   divisor_t       divisor value at the default width
package clk_div_pkg;

  localparam int CW_DEFAULT      = 32;
  localparam int DEF_DIV_DEFAULT = 5000000;

  typedef logic [CW_DEFAULT-1:0] divisor_t;

  // A single channel still needs a one-bit select port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
// Holds the counter, the active divisor, the shadow divisor (written by
// software at any time) and the registered tick / divided-clock outputs.
// The shadow value is promoted to the active divisor only at wrap, on a
// restart, or while the channel is disabled, so periods never glitch.
// Optional: CLK_DIV_STATUS_EN adds pending_o (shadow differs from active).
// Ports:
//   clk        system clock
//   rst        reset, asynchronous assert (already release-synchronised)
//   en_i       count enable
//   restart_i  realign: zero counter and outputs, load shadow
//   wr_i       shadow divisor write strobe for this channel
//   wr_div_i   divisor value to write
//   tick_o     one-cycle strobe every eff cycles
//   clk_out_o  50% duty clock, period 2*eff
//   pending_o  (CLK_DIV_STATUS_EN only) shadow != active
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW      = CW_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          restart_i,
  input  logic          wr_i,
  input  logic [CW-1:0] wr_div_i,
`ifdef CLK_DIV_STATUS_EN
  output logic          pending_o,
`endif
  output logic          tick_o,
  output logic          clk_out_o
);

  localparam logic [CW-1:0] RST_DIV = CW'(DEF_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] act_q, act_d;
  logic [CW-1:0] shd_q, shd_d;
  logic          tick_q, tick_d;
  logic          clk_q, clk_d;
  logic [CW-1:0] eff;
  logic [CW-1:0] shd_fwd;
  logic          term;

  always_comb begin
    // Divisors 0 and 1 both mean "every cycle".
    eff     = (act_q < CW'(2)) ? CW'(1) : act_q;
    term    = en_i && (cnt_q == (eff - CW'(1)));
    // A write in the same cycle as a transfer is forwarded into it.
    shd_fwd = wr_i ? wr_div_i : shd_q;

    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_fwd;
    tick_d = 1'b0;
    clk_d  = clk_q;

    if (restart_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
      act_d = shd_fwd;
    end else if (en_i) begin
      tick_d = term;
      if (term) begin
        cnt_d = '0;
        clk_d = ~clk_q;
        act_d = shd_fwd;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (shd_q != act_q) begin
      // Idle channel adopts a new divisor at once and starts fresh.
      act_d = shd_q;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      shd_q  <= RST_DIV;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;

`ifdef CLK_DIV_STATUS_EN
  logic pend_q;

  // Compare next-state values so the flag tracks shd_q != act_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= (shd_d != act_d);
  end

  assign pending_o = pend_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel programmable tick / divided-clock generator.
// Decodes divisor writes to per-channel strobes (out-of-range channel
// numbers match nothing and are dropped), fans out sync_restart, and
// synchronises the release of the asynchronous reset.
// Optional: define CLK_DIV_STATUS_EN to add the pending output.
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   en[NCH]       per-channel count enable
//   sync_restart  realign all channels
//   wr_en         divisor write strobe
//   wr_ch[IW]     write target channel
//   wr_div[CW]    new divisor
//   tick[NCH]     registered one-cycle strobes
//   clk_out[NCH]  registered divided clocks
//   pending[NCH]  (CLK_DIV_STATUS_EN only) shadow divisor not yet active
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int CW      = CW_DEFAULT,
  parameter  int DEF_DIV = DEF_DIV_DEFAULT,
  localparam int IW      = idx_w(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] en,
  input  logic           sync_restart,
  input  logic           wr_en,
  input  logic [IW-1:0]  wr_ch,
  input  logic [CW-1:0]  wr_div,
`ifdef CLK_DIV_STATUS_EN
  output logic [NCH-1:0] pending,
`endif
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out
);

  // Reset asserts immediately, releases two clock edges after reset drops.
  logic [1:0] rst_sync_q;
  logic       chan_rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign chan_rst = rst_sync_q[1];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_en && (wr_ch == IW'(i));

    clk_div_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (chan_rst),
      .en_i      (en[i]),
      .restart_i (sync_restart),
      .wr_i      (wr_sel),
      .wr_div_i  (wr_div),
`ifdef CLK_DIV_STATUS_EN
      .pending_o (pending[i]),
`endif
      .tick_o    (tick[i]),
      .clk_out_o (clk_out[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: checks clk_div_multi (NCH=2, and an NCH=3 copy so that
// an out-of-range channel number, 3, is expressible) against a behavioural
// per-channel model of counters, divisors and outputs.
module tb_clk_div_multi;

  localparam int CW = 8;
  localparam int DD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   en = '0;
  logic         sync_restart = 1'b0;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_ch = '0;
  logic [CW-1:0] wr_div = '0;

  logic [1:0] tick2, clk2;
  logic [2:0] tick3, clk3;
  logic       wr_en2;
  assign wr_en2 = wr_en && (wr_ch < 2'd2);

`ifdef CLK_DIV_STATUS_EN
  logic [1:0] pend2;
  logic [2:0] pend3;
`endif

  clk_div_multi #(.NCH(2), .CW(CW), .DEF_DIV(DD)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en[1:0]),
    .sync_restart (sync_restart),
    .wr_en        (wr_en2),
    .wr_ch        (wr_ch[0]),
    .wr_div       (wr_div),
`ifdef CLK_DIV_STATUS_EN
    .pending      (pend2),
`endif
    .tick         (tick2),
    .clk_out      (clk2)
  );

  clk_div_multi #(.NCH(3), .CW(CW), .DEF_DIV(DD)) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sync_restart (sync_restart),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_div       (wr_div),
`ifdef CLK_DIV_STATUS_EN
    .pending      (pend3),
`endif
    .tick         (tick3),
    .clk_out      (clk3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel: position in its period, divisor in use, divisor requested.
  int  m_pos[3], m_div[3], m_req[3];
  bit  m_tick[3], m_clk[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 0; m_div[i] = DD; m_req[i] = DD;
      m_tick[i] = 0; m_clk[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic [2:0] e, input bit rs,
                                     input bit we, input int wc, input int wd);
    for (int i = 0; i < 3; i++) begin
      int period = (m_div[i] < 2) ? 1 : m_div[i];
      int req    = (we && wc == i) ? wd : m_req[i];
      bit wrap   = e[i] && (m_pos[i] == period - 1);
      if (rs) begin
        m_pos[i] = 0; m_tick[i] = 0; m_clk[i] = 0; m_div[i] = req;
      end else if (e[i]) begin
        m_tick[i] = wrap;
        m_pos[i]  = wrap ? 0 : m_pos[i] + 1;
        if (wrap) begin
          m_clk[i] = !m_clk[i];
          m_div[i] = req;
        end
      end else begin
        m_tick[i] = 0;
        if (m_req[i] != m_div[i]) begin
          m_div[i] = m_req[i]; m_pos[i] = 0;
        end
      end
      m_req[i] = req;
    end
  endfunction

  function automatic logic [2:0] exp_tick();
    return {m_tick[2], m_tick[1], m_tick[0]};
  endfunction
  function automatic logic [2:0] exp_clk();
    return {m_clk[2], m_clk[1], m_clk[0]};
  endfunction
  function automatic logic [2:0] exp_pend();
    logic [2:0] p;
    for (int i = 0; i < 3; i++) p[i] = (m_req[i] != m_div[i]);
    return p;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_tick2"}, 32'(tick2), 32'(exp_tick() & 3'b011));
    check({tag, "_clk2"},  32'(clk2),  32'(exp_clk()  & 3'b011));
    check({tag, "_tick3"}, 32'(tick3), 32'(exp_tick()));
    check({tag, "_clk3"},  32'(clk3),  32'(exp_clk()));
`ifdef CLK_DIV_STATUS_EN
    check({tag, "_pend2"}, 32'(pend2), 32'(exp_pend() & 3'b011));
    check({tag, "_pend3"}, 32'(pend3), 32'(exp_pend()));
`endif
  endtask

  // ---------------- driver ----------------
  // One clock: compare state, drive the next inputs, advance the model.
  task automatic cyc(input string tag, input logic [2:0] e, input bit rs,
                     input bit we, input int wc, input int wd);
    @(negedge clk);
    compare_all(tag);
    en = e; sync_restart = rs; wr_en = we; wr_ch = 2'(wc); wr_div = CW'(wd);
    model_step(e, rs, we, wc, wd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc("idle", 3'b000, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2;
    check("rst_tick", 32'({tick3, tick2}), 32'd0);
    check("rst_clk",  32'({clk3, clk2}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(4);

    // All channels enabled at default divisor 4.
    for (int j = 0; j < 16; j++) begin
      cyc("t1", 3'b111, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("t1_tick_pat", 32'(tick2), (((j + 1) % 4) == 0) ? 32'd3 : 32'd0);
      check("t1_clk_pat",  32'(clk2),  ((((j + 1) / 4) % 2) == 1) ? 32'd3 : 32'd0);
    end

    // Shrink ch0 to 2 mid-period.
    cyc("t2", 3'b111, 0, 1, 0, 2);
    for (int j = 0; j < 12; j++) cyc("t2", 3'b111, 0, 0, 0, 0);

    // ch1 divisor 0, then restart.
    cyc("t3", 3'b111, 0, 1, 1, 0);
    cyc("t3", 3'b111, 1, 0, 0, 0);
    for (int j = 0; j < 8; j++) cyc("t3", 3'b111, 0, 0, 0, 0);

    // ch0 disabled for 10 cycles.
    for (int j = 0; j < 10; j++) cyc("t4", 3'b110, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++)  cyc("t4", 3'b111, 0, 0, 0, 0);

    // Out-of-range channel write.
    cyc("t5", 3'b111, 0, 1, 3, 7);
    for (int j = 0; j < 10; j++) cyc("t5", 3'b111, 0, 0, 0, 0);

    // Randomised traffic.
    for (int j = 0; j < 2000; j++) begin
      logic [2:0] e;
      for (int b = 0; b < 3; b++) e[b] = ($urandom_range(0, 9) != 0);
      cyc("rnd", e, ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
          $urandom_range(0, 3), $urandom_range(0, 9));
    end

    // Reset mid-period, restore default divisor.
    cyc("t6", 3'b111, 1, 0, 0, 0);
    for (int j = 0; j < 3; j++) cyc("t6", 3'b111, 0, 0, 0, 0);
    @(negedge clk);
    compare_all("t6_pre");
    en = '0;
    #2 reset = 1'b1;
    #1;
    check("t6_rst_tick", 32'({tick3, tick2}), 32'd0);
    check("t6_rst_clk",  32'({clk3, clk2}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(4);
    for (int j = 0; j < 12; j++) begin
      cyc("t6_run", 3'b111, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("t6_tick_pat", 32'(tick3), (((j + 1) % 4) == 0) ? 32'd7 : 32'd0);
    end
    @(negedge clk);
    compare_all("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
